// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//
// The datapath side (master) drives the ID/EX hazard information.
// The controller side (slave) returns the pipeline-register controls,
// the multiply status and the performance counters.
//
// Signals:
//   ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt   source operands of the ID instruction
//   EX_MemRead, EX_RegWrite, EX_Rd       load/writeback info of the EX instruction
//   EX_BranchTaken, EX_MulStart          control-flow and multiply events in EX
//   PC_Stall, IFID_Stall, IFID_Flush,
//   IDEX_Stall, IDEX_Flush, EXMEM_Flush  pipeline-register controls
//   MulBusy, MulDone                     multiply sequencer status
//   StallCount, FlushCount               saturating performance counters
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [REG_W-1:0] EX_Rd;
  logic             EX_BranchTaken;
  logic             EX_MulStart;
  logic             PC_Stall;
  logic             IFID_Stall;
  logic             IFID_Flush;
  logic             IDEX_Stall;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic             MulBusy;
  logic             MulDone;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
    output EX_MemRead, EX_RegWrite, EX_Rd, EX_BranchTaken, EX_MulStart,
    input  PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush, EXMEM_Flush,
    input  MulBusy, MulDone, StallCount, FlushCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
    input  EX_MemRead, EX_RegWrite, EX_Rd, EX_BranchTaken, EX_MulStart,
    output PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush, EXMEM_Flush,
    output MulBusy, MulDone, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage MIPS32 core.
//
// Produces stall/flush controls for the PC and the IF/ID, ID/EX and EX/MEM
// pipeline registers. Handles taken branches resolved in EX, multi-cycle
// multiplies held in EX, and load-use hazards, with priority
// branch > multiply > load-use. Also keeps saturating counters of stall
// cycles and flush cycles.
//
// Ports:
//   Clk    core clock
//   Reset  synchronous active-high reset (controls are also forced low
//          combinationally while it is high)
//   bus    pipeline_hazard_ctrl_if.slave: hazard inputs in, controls,
//          multiply status and counters out
module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int REG_W       = 5,
  parameter int CNT_W       = 32
) (
  input logic                  Clk,
  input logic                  Reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int MW = $clog2(MUL_LATENCY) + 1;
  localparam logic [REG_W-1:0] ZeroReg = '0;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t           state;
  logic [MW-1:0]    mcnt;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  logic inIdle;
  logic busy;
  logic branch;
  logic mulGo;
  logic hazard;
  logic loadUse;

  // Event decode. In MUL_BUSY the EX stage is frozen, so branch and multiply
  // start inputs are stale and are only honoured from IDLE. A one-cycle
  // multiply needs no sequencing at all, so it never starts the FSM.
  always_comb begin
    inIdle  = (state == IDLE);
    busy    = (state == MUL_BUSY);
    branch  = inIdle & bus.EX_BranchTaken;
    mulGo   = inIdle & ~bus.EX_BranchTaken & bus.EX_MulStart & (MUL_LATENCY > 1);
    hazard  = bus.EX_MemRead & bus.EX_RegWrite & (bus.EX_Rd != ZeroReg) &
              ((bus.ID_UsesRs & (bus.ID_Rs == bus.EX_Rd)) |
               (bus.ID_UsesRt & (bus.ID_Rt == bus.EX_Rd)));
    loadUse = inIdle & ~branch & ~mulGo & hazard;
  end

  // Pipeline controls are combinational so they act in the same cycle the
  // hazard is seen. Reset masks everything so the pipeline registers
  // clear cleanly while the core is held.
  always_comb begin
    bus.PC_Stall    = ~Reset & (busy | loadUse);
    bus.IFID_Stall  = ~Reset & (busy | loadUse);
    bus.IFID_Flush  = ~Reset & branch;
    bus.IDEX_Stall  = ~Reset & busy;
    bus.IDEX_Flush  = ~Reset & (branch | loadUse);
    bus.EXMEM_Flush = ~Reset & busy;
    bus.MulBusy     = ~Reset & busy;
    bus.MulDone     = ~Reset & busy & (mcnt == MW'(1));
    bus.StallCount  = stallCnt;
    bus.FlushCount  = flushCnt;
  end

  // Multiply sequencer. The start cycle itself is not stalled, so the busy
  // period is MUL_LATENCY-1 cycles, counted down to 1.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      mcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mulGo) begin
            state <= MUL_BUSY;
            mcnt  <= MW'(MUL_LATENCY - 1);
          end
        end
        MUL_BUSY: begin
          mcnt <= mcnt - MW'(1);
          if (mcnt == MW'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          mcnt  <= '0;
        end
      endcase
    end
  end

  // Performance counters stick at all-ones so a long run never reads as a
  // small count after wrapping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (bus.PC_Stall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if ((bus.IFID_Flush || bus.IDEX_Flush) && (flushCnt != '1)) begin
        flushCnt <= flushCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl.
// dut  : default parameters (MUL_LATENCY=4, CNT_W=32).
// dut2 : MUL_LATENCY=1, CNT_W=3, used for the counter saturation and
//        single-cycle multiply cases.
module tb_pipeline_hazard_ctrl;

  logic Clk;
  logic Reset;
  int   compared;
  int   mismatched;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(3))  bus2 ();

  pipeline_hazard_ctrl #(.MUL_LATENCY(4), .REG_W(5), .CNT_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  pipeline_hazard_ctrl #(.MUL_LATENCY(1), .REG_W(5), .CNT_W(3)) dut2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.ID_Rs = '0;  bus.ID_Rt = '0;  bus.ID_UsesRs = 0;  bus.ID_UsesRt = 0;
    bus.EX_MemRead = 0;  bus.EX_RegWrite = 0;  bus.EX_Rd = '0;
    bus.EX_BranchTaken = 0;  bus.EX_MulStart = 0;
    bus2.ID_Rs = '0; bus2.ID_Rt = '0; bus2.ID_UsesRs = 0; bus2.ID_UsesRt = 0;
    bus2.EX_MemRead = 0; bus2.EX_RegWrite = 0; bus2.EX_Rd = '0;
    bus2.EX_BranchTaken = 0; bus2.EX_MulStart = 0;
  endtask

  task automatic setLoadUse(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                            input logic usesRs, input logic usesRt);
    bus.EX_MemRead = 1; bus.EX_RegWrite = 1; bus.EX_Rd = rd;
    bus.ID_Rs = rs; bus.ID_Rt = rt; bus.ID_UsesRs = usesRs; bus.ID_UsesRt = usesRt;
  endtask

  task automatic test_reset();
    clearInputs();
    Reset = 1;
    bus.EX_BranchTaken = 1;
    setLoadUse(5'd8, 5'd8, 5'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if ({bus.PC_Stall, bus.IFID_Stall, bus.IFID_Flush, bus.IDEX_Stall,
           bus.IDEX_Flush, bus.EXMEM_Flush, bus.MulBusy, bus.MulDone} !== 8'h00) begin
        mismatched++;
        $display("[TB] FAIL reset_ctrl cycle %0d: got %b expected 00000000", i,
                 {bus.PC_Stall, bus.IFID_Stall, bus.IFID_Flush, bus.IDEX_Stall,
                  bus.IDEX_Flush, bus.EXMEM_Flush, bus.MulBusy, bus.MulDone});
      end
    end
    Reset = 0;
    clearInputs();
    step();
    compared++;
    if (bus.StallCount !== 32'd0 || bus.FlushCount !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", bus.StallCount, bus.FlushCount);
    end
  endtask

  task automatic test_load_use();
    setLoadUse(5'd8, 5'd8, 5'd0, 1, 0);
    #1;
    compared++;
    if ({bus.PC_Stall, bus.IFID_Stall, bus.IDEX_Flush, bus.IFID_Flush, bus.IDEX_Stall} !== 5'b11100) begin
      mismatched++;
      $display("[TB] FAIL loaduse_rs: got %b expected 11100",
               {bus.PC_Stall, bus.IFID_Stall, bus.IDEX_Flush, bus.IFID_Flush, bus.IDEX_Stall});
    end
    step();
    clearInputs();
    #1;
    compared++;
    if (bus.StallCount !== 32'd1 || bus.FlushCount !== 32'd1 || bus.PC_Stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL loaduse_count: got %0d/%0d stall=%b expected 1/1 stall=0",
               bus.StallCount, bus.FlushCount, bus.PC_Stall);
    end
    setLoadUse(5'd0, 5'd0, 5'd0, 1, 1);
    #1;
    compared++;
    if (bus.PC_Stall !== 1'b0 || bus.IDEX_Flush !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL loaduse_r0: got stall=%b flush=%b expected 0/0", bus.PC_Stall, bus.IDEX_Flush);
    end
    step();
    setLoadUse(5'd9, 5'd3, 5'd9, 1, 1);
    #1;
    compared++;
    if (bus.PC_Stall !== 1'b1 || bus.IDEX_Flush !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL loaduse_rt: got stall=%b flush=%b expected 1/1", bus.PC_Stall, bus.IDEX_Flush);
    end
    step();
    setLoadUse(5'd9, 5'd3, 5'd9, 1, 0);
    #1;
    compared++;
    if (bus.PC_Stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL loaduse_rt_unused: got stall=%b expected 0", bus.PC_Stall);
    end
    step();
    clearInputs();
    #1;
    compared++;
    if (bus.StallCount !== 32'd2 || bus.FlushCount !== 32'd2) begin
      mismatched++;
      $display("[TB] FAIL loaduse_count2: got %0d/%0d expected 2/2", bus.StallCount, bus.FlushCount);
    end
  endtask

  task automatic test_multiply();
    bus.EX_MulStart = 1;
    #1;
    compared++;
    if (bus.MulBusy !== 1'b0 || bus.PC_Stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mul_start_cycle: got busy=%b stall=%b expected 0/0", bus.MulBusy, bus.PC_Stall);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      clearInputs();
      if (i == 2) bus.EX_BranchTaken = 1;
      #1;
      compared++;
      if ({bus.MulBusy, bus.PC_Stall, bus.IFID_Stall, bus.IDEX_Stall, bus.EXMEM_Flush,
           bus.IFID_Flush, bus.IDEX_Flush, bus.MulDone} !== {7'b1111100, (i == 3)}) begin
        mismatched++;
        $display("[TB] FAIL mul_busy cycle %0d: got %b expected %b", i,
                 {bus.MulBusy, bus.PC_Stall, bus.IFID_Stall, bus.IDEX_Stall, bus.EXMEM_Flush,
                  bus.IFID_Flush, bus.IDEX_Flush, bus.MulDone}, {7'b1111100, (i == 3)});
      end
    end
    step();
    clearInputs();
    #1;
    compared++;
    if (bus.MulBusy !== 1'b0 || bus.PC_Stall !== 1'b0 || bus.StallCount !== 32'd5 || bus.FlushCount !== 32'd2) begin
      mismatched++;
      $display("[TB] FAIL mul_after: got busy=%b stall=%b counts %0d/%0d expected 0/0 5/2",
               bus.MulBusy, bus.PC_Stall, bus.StallCount, bus.FlushCount);
    end
  endtask

  task automatic test_branch_priority();
    step();
    bus.EX_BranchTaken = 1;
    bus.EX_MulStart = 1;
    #1;
    compared++;
    if ({bus.IFID_Flush, bus.IDEX_Flush, bus.PC_Stall, bus.IFID_Stall} !== 4'b1100) begin
      mismatched++;
      $display("[TB] FAIL branch_mul: got %b expected 1100",
               {bus.IFID_Flush, bus.IDEX_Flush, bus.PC_Stall, bus.IFID_Stall});
    end
    step();
    clearInputs();
    #1;
    compared++;
    if (bus.MulBusy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL branch_mul_nobusy: got busy=%b expected 0", bus.MulBusy);
    end
    bus.EX_BranchTaken = 1;
    setLoadUse(5'd4, 5'd4, 5'd4, 1, 1);
    #1;
    compared++;
    if ({bus.IFID_Flush, bus.IDEX_Flush, bus.PC_Stall, bus.IFID_Stall, bus.IDEX_Stall} !== 5'b11000) begin
      mismatched++;
      $display("[TB] FAIL branch_loaduse: got %b expected 11000",
               {bus.IFID_Flush, bus.IDEX_Flush, bus.PC_Stall, bus.IFID_Stall, bus.IDEX_Stall});
    end
    step();
    clearInputs();
    #1;
    compared++;
    if (bus.StallCount !== 32'd5 || bus.FlushCount !== 32'd4) begin
      mismatched++;
      $display("[TB] FAIL branch_counts: got %0d/%0d expected 5/4", bus.StallCount, bus.FlushCount);
    end
  endtask

  task automatic test_reset_mid_mul();
    int busyCycles;
    int doneCycles;
    bus.EX_MulStart = 1;
    step();
    clearInputs();
    #1;
    compared++;
    if (bus.MulBusy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midmul_busy1: got %b expected 1", bus.MulBusy);
    end
    step();
    Reset = 1;
    #1;
    compared++;
    if (bus.MulBusy !== 1'b0 || bus.MulDone !== 1'b0 || bus.PC_Stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midmul_reset_mask: got busy=%b done=%b stall=%b expected 0/0/0",
               bus.MulBusy, bus.MulDone, bus.PC_Stall);
    end
    step();
    Reset = 0;
    #1;
    compared++;
    if (bus.MulBusy !== 1'b0 || bus.MulDone !== 1'b0 || bus.StallCount !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL midmul_idle: got busy=%b done=%b stall_count=%0d expected 0/0/0",
               bus.MulBusy, bus.MulDone, bus.StallCount);
    end
    bus.EX_MulStart = 1;
    busyCycles = 0;
    doneCycles = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      clearInputs();
      #1;
      if (bus.MulBusy === 1'b1) busyCycles++;
      if (bus.MulDone === 1'b1) doneCycles++;
    end
    compared++;
    if (busyCycles != 3 || doneCycles != 1 || bus.StallCount !== 32'd3) begin
      mismatched++;
      $display("[TB] FAIL midmul_restart: got busy=%0d done=%0d stall_count=%0d expected 3/1/3",
               busyCycles, doneCycles, bus.StallCount);
    end
  endtask

  task automatic test_saturation();
    bus2.EX_MemRead = 1; bus2.EX_RegWrite = 1; bus2.EX_Rd = 5'd7;
    bus2.ID_Rs = 5'd7; bus2.ID_UsesRs = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      #1;
      compared++;
      if (bus2.StallCount !== 3'((i > 7) ? 7 : i) || bus2.FlushCount !== 3'((i > 7) ? 7 : i)) begin
        mismatched++;
        $display("[TB] FAIL sat_count step %0d: got %0d/%0d expected %0d", i,
                 bus2.StallCount, bus2.FlushCount, (i > 7) ? 7 : i);
      end
    end
    clearInputs();
    bus2.EX_MulStart = 1;
    #1;
    step();
    clearInputs();
    #1;
    compared++;
    if (bus2.MulBusy !== 1'b0 || bus2.MulDone !== 1'b0 || bus2.PC_Stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lat1_mul: got busy=%b done=%b stall=%b expected 0/0/0",
               bus2.MulBusy, bus2.MulDone, bus2.PC_Stall);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Reset      = 1;
    clearInputs();
    test_reset();
    test_load_use();
    test_multiply();
    test_branch_priority();
    test_reset_mid_mul();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage MIPS32 core. It generates the stall and flush controls that drive the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.
- Detects load-use hazards and taken branches resolved in EX.
- Sequences a multi-cycle multiply held in EX.
- Keeps saturating performance counters for stall and flush cycles.
One instance per core.

Parameters:
MUL_LATENCY, 4, total EX cycles a multiply occupies (>=1)
REG_W, 5, register-address width
CNT_W, 32, performance counter width

Ports:
Clk  in  1  core clock
Reset  in  1  synchronous active-high reset
ID_Rs  in  REG_W  rs field of instruction in ID
ID_Rt  in  REG_W  rt field of instruction in ID
ID_UsesRs  in  1  ID instruction reads rs
ID_UsesRt  in  1  ID instruction reads rt
EX_MemRead  in  1  instruction in EX is a load
EX_RegWrite  in  1  instruction in EX writes a register
EX_Rd  in  REG_W  destination register of the EX instruction
EX_BranchTaken  in  1  branch/jump in EX resolved taken
EX_MulStart  in  1  multiply entered EX this cycle
PC_Stall  out  1  hold PC
IFID_Stall  out  1  hold IF/ID register
IFID_Flush  out  1  zero IF/ID register
IDEX_Stall  out  1  hold ID/EX register
IDEX_Flush  out  1  zero ID/EX register (bubble)
EXMEM_Flush  out  1  zero EX/MEM register (bubble)
MulBusy  out  1  multiply sequencer active
MulDone  out  1  single-cycle pulse on the last multiply cycle
StallCount  out  CNT_W  cycles with PC_Stall=1
FlushCount  out  CNT_W  cycles with IFID_Flush=1 or IDEX_Flush=1

Behaviour:
- Reset behaviour:
  - Clk and Reset only; Reset is synchronous and active-high.
  - While Reset=1, all stall, flush, MulBusy and MulDone outputs are forced to 0 combinationally.
  - At the clock edge, FSM returns to IDLE, the multiply counter clears to 0, and StallCount/FlushCount clear to 0.
  - Reset mid-multiply aborts the multiply with no MulDone pulse.
- FSM states: IDLE, MUL_BUSY. Down-counter mcnt, width ceil(log2(MUL_LATENCY))+1.
- Priority, evaluated combinationally each cycle: branch > multiply > load-use.
- Branch (IDLE, EX_BranchTaken=1):
  - IFID_Flush=1 and IDEX_Flush=1; PC not stalled.
  - EX_MulStart is ignored in that cycle; no multiply starts.
- Multiply start (IDLE, EX_MulStart=1, no branch, MUL_LATENCY>1):
  - Next state MUL_BUSY, mcnt <= MUL_LATENCY-1.
  - No stall in the start cycle itself.
- MUL_BUSY:
  - Outputs: PC_Stall=IFID_Stall=IDEX_Stall=1, EXMEM_Flush=1, MulBusy=1.
  - EX_BranchTaken and EX_MulStart are ignored: EX is frozen, so neither can be new.
  - mcnt decrements each cycle.
  - When mcnt==1: MulDone=1, and the next state is IDLE.
  - Busy length is exactly MUL_LATENCY-1 cycles.
- MUL_LATENCY=1: EX_MulStart has no effect; the FSM never leaves IDLE and MulDone is never asserted.
- Load-use (IDLE, no branch, no multiply start):
  - Condition: hazard = EX_MemRead & EX_RegWrite & (EX_Rd!=0) & ((ID_UsesRs & ID_Rs==EX_Rd) | (ID_UsesRt & ID_Rt==EX_Rd)).
  - When hazard=1: PC_Stall=IFID_Stall=1 and IDEX_Flush=1 for that cycle only.
  - A load to $0 never stalls.
- IFID_Flush and IFID_Stall are never both 1. IDEX_Stall and IDEX_Flush are never both 1.
- Counters:
  - Registered. Each increments by 1 at the clock edge for every qualifying non-reset cycle.
  - Each saturates at all-ones and does not wrap.
- All stall/flush outputs are combinational from state and inputs, with zero-cycle latency. Counters have one-cycle latency.

Test Plan:
- Reset held 3 cycles while EX_BranchTaken=1 and a load-use match is present -> all stall/flush outputs 0; counters 0 after release.
- EX_MemRead=1, EX_RegWrite=1, EX_Rd=8, ID_Rs=8, ID_UsesRs=1 for one cycle -> PC_Stall=IFID_Stall=IDEX_Flush=1 that cycle; StallCount=1 and FlushCount=1 next cycle. Repeat with EX_Rd=0 -> no stall.
- EX_MulStart pulse, MUL_LATENCY=4 -> MulBusy=1 and stalls asserted for exactly 3 cycles starting the next cycle; MulDone=1 on the 3rd; IDLE afterwards; StallCount=3.
- EX_BranchTaken=1 and EX_MulStart=1 in the same cycle -> IFID_Flush=IDEX_Flush=1, PC_Stall=0, no MUL_BUSY entry. Load-use match plus branch -> only branch controls asserted.
- Reset asserted on the 2nd MUL_BUSY cycle -> next cycle IDLE, MulBusy=0, no MulDone. A new EX_MulStart then gives the full 3-cycle busy period.
- Preload by forcing StallCount to 2^CNT_W-2, then 3 stall cycles -> StallCount ends at 2^CNT_W-1 with no wrap.
